// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one RV32 load/store per handshake, sub-word loads
// extracted and extended, SB/SH done as read-modify-write on a word-only dmem port.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r_enable,
  output logic              mem_w_enable,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, RESP} state_t;

  state_t      state;
  logic        st_store;
  logic [2:0]  st_funct3;
  logic [1:0]  st_lane;
  logic [15:0] st_wdata;

  logic              req_err;
  logic [DATA_W-1:0] lane_shift;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP);
  assign mem_r_enable = (state == RD);
  assign mem_w_enable = (state == WR);

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = req_addr[0];
      3'b010:         req_err = (req_addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (req_store && req_funct3[2]) req_err = 1'b1;
  end

  always_comb begin
    lane_shift = mem_r_data >> {st_lane, 3'b000};
    sel_byte   = lane_shift[7:0];
    sel_half   = st_lane[1] ? mem_r_data[31:16] : mem_r_data[15:0];
    load_data  = mem_r_data;
    merge_data = mem_r_data;
    case (st_funct3[1:0])
      2'b00: begin
        load_data  = {{24{sel_byte[7] & ~st_funct3[2]}}, sel_byte};
        merge_data = (mem_r_data & ~(32'h0000_00FF << {st_lane, 3'b000}))
                   | ({24'h0, st_wdata[7:0]} << {st_lane, 3'b000});
      end
      2'b01: begin
        load_data  = {{16{sel_half[15] & ~st_funct3[2]}}, sel_half};
        merge_data = st_lane[1] ? {st_wdata, mem_r_data[15:0]}
                                : {mem_r_data[31:16], st_wdata};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      st_store   <= 1'b0;
      st_funct3  <= 3'b000;
      st_lane    <= 2'b00;
      st_wdata   <= 16'h0;
      mem_addr   <= '0;
      mem_w_data <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          st_store  <= req_store;
          st_funct3 <= req_funct3;
          st_lane   <= req_addr[1:0];
          st_wdata  <= req_wdata[15:0];
          mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
          if (req_err) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else if (req_store && req_funct3 == 3'b010) begin
            mem_w_data <= req_wdata;
            state      <= WR;
          end else begin
            state <= RD;
          end
        end
        RD: state <= RWAIT;
        RWAIT: if (mem_ready) begin
          if (st_store) begin
            mem_w_data <= merge_data;
            state      <= WR;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            state      <= RESP;
          end
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
